// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - debounced operand entry and ALU result capture front end
module operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       key_load,
  input  logic       key_clear,
  input  logic [7:0] alu_in,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] select,
  output logic [7:0] result,
  output logic       result_valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    LOAD_A   = 2'b00,
    LOAD_B   = 2'b01,
    LOAD_SEL = 2'b10,
    SHOW     = 2'b11
  } state_t;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  state_t     cur_state;
  state_t     nxt_state;

  logic       load_meta;
  logic       load_sync;
  logic       clear_meta;
  logic       clear_sync;

  logic       load_level;
  logic [7:0] db_cnt;
  logic       press;
  logic       db_differs;
  logic       db_done;

  logic       act_load_a;
  logic       act_load_b;
  logic       act_load_sel;
  logic       act_capture;

  // Two-flop synchronizers for both raw keys.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_meta  <= 1'b0;
      load_sync  <= 1'b0;
      clear_meta <= 1'b0;
      clear_sync <= 1'b0;
    end else begin
      load_meta  <= key_load;
      load_sync  <= load_meta;
      clear_meta <= key_clear;
      clear_sync <= clear_meta;
    end
  end

  // The accepted level flips once the synchronized level has disagreed for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    db_differs = (load_sync != load_level);
    db_done    = db_differs && ((db_cnt + 8'd1) == DB_LIMIT);
  end

  // Debounce counter, accepted level and the one-cycle press pulse on a rising acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_level <= 1'b0;
      db_cnt     <= 8'd0;
      press      <= 1'b0;
    end else begin
      press <= db_done && !load_level;
      if (!db_differs) begin
        db_cnt <= 8'd0;
      end else if (db_done) begin
        load_level <= ~load_level;
        db_cnt     <= 8'd0;
      end else begin
        db_cnt <= db_cnt + 8'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= LOAD_A;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next state and datapath strobes; clear overrides a simultaneous press.
  always_comb begin
    nxt_state    = cur_state;
    act_load_a   = 1'b0;
    act_load_b   = 1'b0;
    act_load_sel = 1'b0;
    act_capture  = 1'b0;
    if (clear_sync) begin
      nxt_state = LOAD_A;
    end else if (press) begin
      case (cur_state)
        LOAD_A, SHOW: begin
          act_load_a = 1'b1;
          nxt_state  = LOAD_B;
        end
        LOAD_B: begin
          act_load_b = 1'b1;
          nxt_state  = LOAD_SEL;
        end
        default: begin
          act_load_sel = 1'b1;
          nxt_state    = SHOW;
        end
      endcase
    end else if (cur_state == SHOW && !result_valid) begin
      // result_valid is always low on SHOW entry, so this fires only on the first SHOW cycle.
      act_capture = 1'b1;
    end
  end

  // Operand, select and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A            <= 4'd0;
      B            <= 4'd0;
      select       <= 3'd0;
      result       <= 8'd0;
      result_valid <= 1'b0;
    end else if (clear_sync) begin
      A            <= 4'd0;
      B            <= 4'd0;
      select       <= 3'd0;
      result       <= 8'd0;
      result_valid <= 1'b0;
    end else begin
      if (act_load_a) begin
        A            <= sw;
        B            <= 4'd0;
        result_valid <= 1'b0;
      end
      if (act_load_b) begin
        B <= sw;
      end
      if (act_load_sel) begin
        select <= sw[2:0];
      end
      if (act_capture) begin
        result       <= alu_in;
        result_valid <= 1'b1;
      end
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed self-checking bench for operand_sequencer
`timescale 1ns/1ps
module tb_operand_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic       key_load;
  logic       key_clear;
  logic [7:0] alu_in;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] select;
  logic [7:0] result;
  logic       result_valid;
  logic [1:0] state;

  int total;
  int bad;

  operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .key_load     (key_load),
    .key_clear    (key_clear),
    .alu_in       (alu_in),
    .A            (A),
    .B            (B),
    .select       (select),
    .result       (result),
    .result_valid (result_valid),
    .state        (state)
  );

  // ALU stand-in: adder of the two operands.
  assign alu_in = {4'd0, A} + {4'd0, B};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press: 7 ticks high covers edges 0..6, then a long release.
  task automatic do_press(input logic [3:0] v);
    sw = v;
    key_load = 1'b1;
    tick(7);
    key_load = 1'b0;
    tick(8);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    total++;
    if ({A, B, select, result, result_valid, state} !== 22'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {A, B, select, result, result_valid, state});
    end
    #2 reset = 1'b0;
    tick(8);
  endtask

  task automatic test_entry;
    sw = 4'd3;
    key_load = 1'b1;
    tick(6);
    total++;
    if (A !== 4'd0 || state !== 2'b00) begin
      bad++;
      $display("FAIL entry_a_early: A=%0d state=%b want A=0 state=00", A, state);
    end
    tick(1);
    total++;
    if (A !== 4'd3 || state !== 2'b01) begin
      bad++;
      $display("FAIL entry_a: A=%0d state=%b want A=3 state=01", A, state);
    end
    key_load = 1'b0;
    tick(8);
    sw = 4'd5;
    key_load = 1'b1;
    tick(6);
    total++;
    if (B !== 4'd0) begin
      bad++;
      $display("FAIL entry_b_early: B=%0d want 0", B);
    end
    tick(1);
    total++;
    if (B !== 4'd5 || state !== 2'b10) begin
      bad++;
      $display("FAIL entry_b: B=%0d state=%b want B=5 state=10", B, state);
    end
    key_load = 1'b0;
    tick(8);
    sw = 4'd2;
    key_load = 1'b1;
    tick(6);
    total++;
    if (select !== 3'd0) begin
      bad++;
      $display("FAIL entry_sel_early: select=%0d want 0", select);
    end
    tick(1);
    total++;
    if (select !== 3'd2 || state !== 2'b11 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL entry_sel: select=%0d state=%b valid=%b want 2 11 0", select, state, result_valid);
    end
    tick(1);
    total++;
    if (result !== 8'h08 || result_valid !== 1'b1) begin
      bad++;
      $display("FAIL entry_capture: result=%h valid=%b want 08 1", result, result_valid);
    end
    key_load = 1'b0;
    tick(8);
    total++;
    if (result !== 8'h08 || result_valid !== 1'b1 || state !== 2'b11) begin
      bad++;
      $display("FAIL entry_hold: result=%h valid=%b state=%b want 08 1 11", result, result_valid, state);
    end
  endtask

  task automatic test_reentry;
    do_press(4'd9);
    total++;
    if (A !== 4'd9 || B !== 4'd0 || result_valid !== 1'b0 || state !== 2'b01 || select !== 3'd2) begin
      bad++;
      $display("FAIL reentry: A=%0d B=%0d valid=%b state=%b sel=%0d want 9 0 0 01 2", A, B, result_valid, state, select);
    end
  endtask

  task automatic test_clear_vs_press;
    sw = 4'd6;
    key_load = 1'b1;
    tick(4);
    key_clear = 1'b1;
    tick(3);
    total++;
    if ({A, B, select, result, result_valid, state} !== 22'd0) begin
      bad++;
      $display("FAIL clear_vs_press: got %h want 0", {A, B, select, result, result_valid, state});
    end
    key_clear = 1'b0;
    key_load = 1'b0;
    tick(8);
    total++;
    if (state !== 2'b00 || A !== 4'd0) begin
      bad++;
      $display("FAIL clear_press_discarded: state=%b A=%0d want 00 0", state, A);
    end
  endtask

  task automatic test_held;
    sw = 4'd7;
    key_load = 1'b1;
    tick(100);
    total++;
    if (A !== 4'd7 || B !== 4'd0 || state !== 2'b01) begin
      bad++;
      $display("FAIL held_key: A=%0d B=%0d state=%b want 7 0 01", A, B, state);
    end
    key_load = 1'b0;
    tick(8);
    total++;
    if (state !== 2'b01) begin
      bad++;
      $display("FAIL held_release: state=%b want 01", state);
    end
  endtask

  task automatic test_bounce;
    int widths [7] = '{1, 2, 1, 2, 1, 2, 1};
    sw = 4'd4;
    for (int i = 0; i < 7; i++) begin
      key_load = (i % 2 == 0);
      tick(widths[i]);
    end
    total++;
    if (state !== 2'b01 || B !== 4'd0) begin
      bad++;
      $display("FAIL bounce_no_step: state=%b B=%0d want 01 0", state, B);
    end
    key_load = 1'b1;
    tick(20);
    total++;
    if (state !== 2'b10 || B !== 4'd4) begin
      bad++;
      $display("FAIL bounce_one_step: state=%b B=%0d want 10 4", state, B);
    end
    key_load = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      key_load = 1'b1;
      tick(3);
      key_load = 1'b0;
      tick(3);
    end
    tick(6);
    total++;
    if (state !== 2'b10 || select !== 3'd0) begin
      bad++;
      $display("FAIL short_pulses: state=%b select=%0d want 10 0", state, select);
    end
  endtask

  task automatic test_clear_show;
    sw = 4'd1;
    key_load = 1'b1;
    tick(7);
    total++;
    if (state !== 2'b11 || select !== 3'd1 || result_valid !== 1'b0) begin
      bad++;
      $display("FAIL show_entry: state=%b sel=%0d valid=%b want 11 1 0", state, select, result_valid);
    end
    tick(1);
    total++;
    if (result !== 8'h0B || result_valid !== 1'b1) begin
      bad++;
      $display("FAIL show_capture: result=%h valid=%b want 0b 1", result, result_valid);
    end
    key_load = 1'b0;
    tick(8);
    key_clear = 1'b1;
    tick(3);
    total++;
    if ({A, B, select, result, result_valid, state} !== 22'd0) begin
      bad++;
      $display("FAIL clear_show: got %h want 0", {A, B, select, result, result_valid, state});
    end
    key_clear = 1'b0;
    tick(4);
  endtask

  task automatic test_async_reset;
    do_press(4'd2);
    do_press(4'd3);
    total++;
    if (state !== 2'b10 || A !== 4'd2 || B !== 4'd3) begin
      bad++;
      $display("FAIL pre_reset: state=%b A=%0d B=%0d want 10 2 3", state, A, B);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({A, B, select, result, result_valid, state} !== 22'd0) begin
      bad++;
      $display("FAIL async_reset: got %h want 0", {A, B, select, result, result_valid, state});
    end
    sw = 4'd5;
    key_load = 1'b1;
    tick(2);
    #2 reset = 1'b0;
    tick(6);
    total++;
    if (state !== 2'b00 || A !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_early: state=%b A=%0d want 00 0", state, A);
    end
    tick(1);
    total++;
    if (state !== 2'b01 || A !== 4'd5) begin
      bad++;
      $display("FAIL post_reset_press: state=%b A=%0d want 01 5", state, A);
    end
    key_load = 1'b0;
    tick(8);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    sw = 4'd0;
    key_load = 1'b0;
    key_clear = 1'b0;
    test_reset();
    test_entry();
    test_reentry();
    test_clear_vs_press();
    test_held();
    test_bounce();
    test_clear_show();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Operand-entry and result-capture front end for the lab ALU datapath. It debounces a load key and steps a state machine through operand A, operand B and the function select, all sampled from a 4-bit switch nibble. It drives the ALU's A/B/select inputs from registers and captures the ALU's 8-bit output into a result register with a valid flag. The ALU consumes operands; this block produces them, so one operand set can be entered on a single nibble of switches.

## Interface
- DEBOUNCE_CYCLES, 4, number of consecutive synchronized-high or synchronized-low cycles needed to accept a key edge. Range 1..255; 8-bit counter.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high. Forces every register and output to its reset value immediately.
- sw  in  4  data nibble, sampled only on an accepted load press.
- key_load  in  1  raw load key, active-high. Asynchronous to clk and bouncy.
- key_clear  in  1  raw clear key, active-high, asynchronous to clk.
- alu_in  in  8  ALU result, combinational function of A, B and select.
- A  out  4  operand A register; reset 0.
- B  out  4  operand B register; reset 0.
- select  out  3  ALU function select register; reset 0.
- result  out  8  captured ALU result; reset 0.
- result_valid  out  1  result holds a capture for the current operand set; reset 0.
- state  out  2  current FSM state encoding; reset 2'b00.

## Operation
- Synchronizers:
  - key_load and key_clear each pass through 2 flops before any use.
  - Both synchronizer chains reset to 0.
- Debounce of load:
  - The counter counts consecutive cycles in which the synchronized level differs from the accepted level.
  - The counter resets to 0 whenever the synchronized level matches the accepted level.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level toggles and the counter clears.
  - A 0->1 toggle of the accepted level produces press, a 1-cycle internal pulse.
  - A 1->0 toggle produces no pulse.
  - A held key therefore yields exactly one press.
- Clear:
  - Acts on the synchronized key_clear level.
  - It is not debounced.
- FSM states: LOAD_A=00, LOAD_B=01, LOAD_SEL=10, SHOW=11.
- FSM transitions on press:
  - LOAD_A: A<=sw, B<=0, result_valid<=0; go to LOAD_B.
  - LOAD_B: B<=sw; go to LOAD_SEL.
  - LOAD_SEL: select<=sw[2:0] (sw[3] ignored); go to SHOW.
  - SHOW, press: identical to the LOAD_A action. A<=sw, B<=0, result_valid<=0; go to LOAD_B. A new entry starts with no idle press.
- Capture in SHOW: on the first cycle in SHOW, result<=alu_in and result_valid<=1. The result is then frozen until the operand set changes.
- Synchronized clear high:
  - A, B, select and result are set to 0 and result_valid<=0.
  - State goes to LOAD_A.
  - The debounce accepted level and counter are not affected.
- Clear and press in the same cycle: clear wins and the press is discarded.
- sw and alu_in are used directly, without synchronization. Switches are static at press time, and alu_in is a function of registered outputs only.

## Timing
- Press latency:
  - First clk edge sampling key_load=1 is edge 0.
  - Synchronized level is high after edge 1.
  - Accepted level toggles at edge 1+DEBOUNCE_CYCLES.
  - press is high for the cycle after that edge.
  - The FSM and registers update at edge 2+DEBOUNCE_CYCLES.
- Release needs DEBOUNCE_CYCLES stable low cycles before the next press can be accepted.
- Glitch rejection: a high or low glitch shorter than DEBOUNCE_CYCLES cycles, after synchronization, has no effect.
- Result capture:
  - state becomes SHOW at edge N, with select already updated at edge N.
  - result and result_valid update at edge N+1.
  - alu_in must settle within one cycle.
- Clear latency: outputs reach reset values 2 edges after key_clear is first sampled high, then 1 more edge. Total is 3 edges from the first sampling edge.
- Reset: asynchronous assertion takes effect with no clock. The first press is possible DEBOUNCE_CYCLES+2 edges after deassertion.
- Reset mid-debounce or mid-sequence: all progress is lost and the block returns to LOAD_A with all outputs 0.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Entry sequence: clean presses with sw=3, 5, 2, and alu_in driven by an A+B model. Required: A=3, B=5, select=2, state=11, then result=8'h08 and result_valid=1 one edge after SHOW. Each register updates exactly 6 edges after its key's first sampled-high edge.
- Bounce: key_load toggles 1-2-1 cycles for 10 cycles, then holds high for 20 cycles. Required: exactly one press and one state step. Pulses of 3 cycles alone cause no step.
- Held key: key_load held high for 100 cycles in LOAD_A. Required: only A loads and state stays at 01.
- Re-entry from SHOW: press with sw=9. Required: A=9, B=0, result_valid=0, state=01. select is kept from the previous set.
- Clear versus press: key_clear and a debounced press land in the same cycle in LOAD_B. Required: state=00 and all outputs 0. Clear alone in SHOW reaches zeros within 3 edges.
- Async reset: assert reset between clk edges during LOAD_SEL. Required: outputs go to 0 immediately. After deassertion, a press less than 6 edges away is not accepted early.
